// File: rtl/gpio_cond_pkg.sv
// Shared constants and helpers for the GPIO input conditioner.
package gpio_cond_pkg;

    // Depth of the per-pin metastability synchroniser.
    localparam int SYNC_STAGES = 2;

    // Counter width able to hold 0..cycles; never narrower than one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/gpio_pin_debounce.sv
// One GPIO pin: two-flop synchroniser, stability counter, debounced level
// and single-cycle rise/fall indications coincident with the level update.
module gpio_pin_debounce
    import gpio_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic rstn,
    input  logic pin_async,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CNT_WIDTH = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [CNT_WIDTH-1:0]   cnt_reg;
    logic                   stable_reg;
    logic                   syn;
    logic                   accept;

    assign syn    = sync_reg[SYNC_STAGES-1];
    // A new level is accepted on the edge where the count reaches its last value.
    assign accept = (syn != stable_reg) && (cnt_reg == CNT_LAST);

    // Plain shift chain: nothing sits between the synchroniser flops.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], pin_async};
        end
    end

    // Count consecutive cycles of disagreement; any agreement restarts the count.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_reg    <= '0;
            stable_reg <= 1'b0;
        end else if (syn == stable_reg) begin
            cnt_reg    <= '0;
        end else if (cnt_reg == CNT_LAST) begin
            stable_reg <= syn;
            cnt_reg    <= '0;
        end else begin
            cnt_reg    <= cnt_reg + CNT_WIDTH'(1);
        end
    end

    assign level = stable_reg;
    assign rise  = accept & syn;
    assign fall  = accept & ~syn;

endmodule

// File: rtl/gpio_input_conditioner.sv
// GPIO input conditioner: output-enable/data pass-through toward the breakout,
// debounced readback toward the master, sticky per-pin edge flags and a
// single level interrupt.
module gpio_input_conditioner
    import gpio_cond_pkg::*;
#(
    parameter int GPIO_WIDTH      = 16,
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [GPIO_WIDTH-1:0] m_t,
    input  logic [GPIO_WIDTH-1:0] m_o,
    output logic [GPIO_WIDTH-1:0] m_i,
    output logic [GPIO_WIDTH-1:0] s_t,
    output logic [GPIO_WIDTH-1:0] s_o,
    input  logic [GPIO_WIDTH-1:0] s_i,
    input  logic [GPIO_WIDTH-1:0] rise_en,
    input  logic [GPIO_WIDTH-1:0] fall_en,
    input  logic [GPIO_WIDTH-1:0] irq_clr,
    output logic [GPIO_WIDTH-1:0] irq_status,
    output logic                  irq
);

    logic [GPIO_WIDTH-1:0] level;
    logic [GPIO_WIDTH-1:0] rise;
    logic [GPIO_WIDTH-1:0] fall;
    logic [GPIO_WIDTH-1:0] ev;
    logic [GPIO_WIDTH-1:0] irq_status_reg;
    logic                  irq_reg;

    // Direction and output data go straight through; the breakout owns the pads.
    assign s_t = m_t;
    assign s_o = m_o;

    // Every pin is conditioned regardless of direction, so outputs read back.
    for (genvar gi = 0; gi < GPIO_WIDTH; gi++) begin : g_pin
        gpio_pin_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_pin (
            .clk       (clk),
            .rstn      (rstn),
            .pin_async (s_i[gi]),
            .level     (level[gi]),
            .rise      (rise[gi]),
            .fall      (fall[gi])
        );
    end

    assign m_i = level;
    assign ev  = (rise & rise_en) | (fall & fall_en);

    // Sticky flags: a new event beats a simultaneous write-1-to-clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            irq_status_reg <= '0;
        end else begin
            irq_status_reg <= ev | (irq_status_reg & ~irq_clr);
        end
    end

    // Interrupt line trails the flag bank by one cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= |irq_status_reg;
        end
    end

    assign irq_status = irq_status_reg;
    assign irq        = irq_reg;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Self-checking bench for gpio_input_conditioner (4 pins, 4-cycle debounce).
module tb_gpio_input_conditioner;

    localparam int W  = 4;
    localparam int DC = 4;

    logic         clk = 1'b0;
    logic         rstn;
    logic [W-1:0] m_t, m_o, m_i, s_t, s_o, s_i;
    logic [W-1:0] rise_en, fall_en, irq_clr, irq_status;
    logic         irq;

    typedef struct {
        string        name;
        logic [W-1:0] exp;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    gpio_input_conditioner #(
        .GPIO_WIDTH      (W),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .m_t        (m_t),
        .m_o        (m_o),
        .m_i        (m_i),
        .s_t        (s_t),
        .s_o        (s_o),
        .s_i        (s_i),
        .rise_en    (rise_en),
        .fall_en    (fall_en),
        .irq_clr    (irq_clr),
        .irq_status (irq_status),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        rstn = 1'b0; s_i = '0; rise_en = '0; fall_en = '0; irq_clr = '0;
        m_t = 4'b1010; m_o = 4'b0110;
        sb.push_back('{"rst_s_t", 4'b1010});
        sb.push_back('{"rst_s_o", 4'b0110});
        sb.push_back('{"rst_m_i", 4'b0000});
        sb.push_back('{"rst_irq_status", 4'b0000});
        sb.push_back('{"rst_irq", 4'b0000});
        step(2);
        e = sb.pop_front(); vectors++;
        if (s_t !== e.exp) begin miscompares++; $display("FAIL %s got %b want %b", e.name, s_t, e.exp); end
        e = sb.pop_front(); vectors++;
        if (s_o !== e.exp) begin miscompares++; $display("FAIL %s got %b want %b", e.name, s_o, e.exp); end
        e = sb.pop_front(); vectors++;
        if (m_i !== e.exp) begin miscompares++; $display("FAIL %s got %b want %b", e.name, m_i, e.exp); end
        e = sb.pop_front(); vectors++;
        if (irq_status !== e.exp) begin miscompares++; $display("FAIL %s got %b want %b", e.name, irq_status, e.exp); end
        e = sb.pop_front(); vectors++;
        if ({3'b000, irq} !== e.exp) begin miscompares++; $display("FAIL %s got %b want %b", e.name, irq, e.exp[0]); end
        rstn = 1'b1;
        step(1);
        $display("test_reset done");
    endtask

    task automatic test_passthrough();
        exp_t e;
        logic [W-1:0] pat [3] = '{4'b0101, 4'b1111, 4'b0011};
        for (int i = 0; i < 3; i++) begin
            m_t = pat[i]; m_o = ~pat[i];
            sb.push_back('{"pass_s_t", pat[i]});
            sb.push_back('{"pass_s_o", ~pat[i]});
            #1;
            e = sb.pop_front(); vectors++;
            if (s_t !== e.exp) begin miscompares++; $display("FAIL %s got %b want %b", e.name, s_t, e.exp); end
            e = sb.pop_front(); vectors++;
            if (s_o !== e.exp) begin miscompares++; $display("FAIL %s got %b want %b", e.name, s_o, e.exp); end
            $display("passthrough m_t=%b m_o=%b", m_t, m_o);
        end
    endtask

    task automatic test_clean_edge();
        exp_t e;
        rise_en = 4'b0001; fall_en = 4'b0000;
        s_i[0] = 1'b1;
        sb.push_back('{"clean_m_i_before", 4'b0000});
        step(DC + 1);
        e = sb.pop_front(); vectors++;
        if (m_i !== e.exp) begin miscompares++; $display("FAIL %s got %b want %b", e.name, m_i, e.exp); end
        sb.push_back('{"clean_m_i", 4'b0001});
        sb.push_back('{"clean_status", 4'b0001});
        sb.push_back('{"clean_irq_lag", 4'b0000});
        step(1);
        e = sb.pop_front(); vectors++;
        if (m_i !== e.exp) begin miscompares++; $display("FAIL %s got %b want %b", e.name, m_i, e.exp); end
        e = sb.pop_front(); vectors++;
        if (irq_status !== e.exp) begin miscompares++; $display("FAIL %s got %b want %b", e.name, irq_status, e.exp); end
        e = sb.pop_front(); vectors++;
        if ({3'b000, irq} !== e.exp) begin miscompares++; $display("FAIL %s got %b want %b", e.name, irq, e.exp[0]); end
        sb.push_back('{"clean_irq", 4'b0001});
        step(1);
        e = sb.pop_front(); vectors++;
        if ({3'b000, irq} !== e.exp) begin miscompares++; $display("FAIL %s got %b want %b", e.name, irq, e.exp[0]); end
        irq_clr = 4'b0001;
        sb.push_back('{"clean_cleared", 4'b0000});
        step(1);
        irq_clr = 4'b0000;
        e = sb.pop_front(); vectors++;
        if (irq_status !== e.exp) begin miscompares++; $display("FAIL %s got %b want %b", e.name, irq_status, e.exp); end
        step(1);
        $display("clean_edge m_i=%b irq_status=%b", m_i, irq_status);
    endtask

    task automatic test_bounce();
        exp_t e;
        rise_en = 4'b0011;
        s_i[1] = 1'b1; step(3);
        s_i[1] = 1'b0; step(3);
        s_i[1] = 1'b1;
        sb.push_back('{"bounce_m_i_held", 4'b0001});
        sb.push_back('{"bounce_no_flag", 4'b0000});
        step(DC + 1);
        e = sb.pop_front(); vectors++;
        if (m_i !== e.exp) begin miscompares++; $display("FAIL %s got %b want %b", e.name, m_i, e.exp); end
        e = sb.pop_front(); vectors++;
        if (irq_status !== e.exp) begin miscompares++; $display("FAIL %s got %b want %b", e.name, irq_status, e.exp); end
        sb.push_back('{"bounce_m_i", 4'b0011});
        sb.push_back('{"bounce_flag", 4'b0010});
        step(1);
        e = sb.pop_front(); vectors++;
        if (m_i !== e.exp) begin miscompares++; $display("FAIL %s got %b want %b", e.name, m_i, e.exp); end
        e = sb.pop_front(); vectors++;
        if (irq_status !== e.exp) begin miscompares++; $display("FAIL %s got %b want %b", e.name, irq_status, e.exp); end
        irq_clr = 4'b0010; step(1); irq_clr = 4'b0000;
        sb.push_back('{"bounce_single_flag", 4'b0000});
        step(10);
        e = sb.pop_front(); vectors++;
        if (irq_status !== e.exp) begin miscompares++; $display("FAIL %s got %b want %b", e.name, irq_status, e.exp); end
        $display("bounce m_i=%b irq_status=%b", m_i, irq_status);
    endtask

    task automatic test_clear_race();
        exp_t e;
        rise_en = 4'b0000; fall_en = 4'b0100;
        s_i[2] = 1'b1;
        step(DC + 2);
        s_i[2] = 1'b0;
        step(DC + 1);
        irq_clr = 4'b0100;
        sb.push_back('{"race_m_i", 4'b0011});
        sb.push_back('{"race_set_wins", 4'b0100});
        step(1);
        irq_clr = 4'b0000;
        e = sb.pop_front(); vectors++;
        if (m_i !== e.exp) begin miscompares++; $display("FAIL %s got %b want %b", e.name, m_i, e.exp); end
        e = sb.pop_front(); vectors++;
        if (irq_status !== e.exp) begin miscompares++; $display("FAIL %s got %b want %b", e.name, irq_status, e.exp); end
        sb.push_back('{"race_irq", 4'b0001});
        step(1);
        e = sb.pop_front(); vectors++;
        if ({3'b000, irq} !== e.exp) begin miscompares++; $display("FAIL %s got %b want %b", e.name, irq, e.exp[0]); end
        irq_clr = 4'b0100;
        sb.push_back('{"race_cleared", 4'b0000});
        sb.push_back('{"race_irq_hold", 4'b0001});
        step(1);
        irq_clr = 4'b0000;
        e = sb.pop_front(); vectors++;
        if (irq_status !== e.exp) begin miscompares++; $display("FAIL %s got %b want %b", e.name, irq_status, e.exp); end
        e = sb.pop_front(); vectors++;
        if ({3'b000, irq} !== e.exp) begin miscompares++; $display("FAIL %s got %b want %b", e.name, irq, e.exp[0]); end
        sb.push_back('{"race_irq_drop", 4'b0000});
        step(1);
        e = sb.pop_front(); vectors++;
        if ({3'b000, irq} !== e.exp) begin miscompares++; $display("FAIL %s got %b want %b", e.name, irq, e.exp[0]); end
        $display("clear_race irq_status=%b irq=%b", irq_status, irq);
    endtask

    task automatic test_enables();
        exp_t e;
        rise_en = 4'b0000; fall_en = 4'b1000;
        s_i[3] = 1'b1;
        sb.push_back('{"en_m_i_high", 4'b1011});
        sb.push_back('{"en_rise_masked", 4'b0000});
        step(DC + 4);
        e = sb.pop_front(); vectors++;
        if (m_i !== e.exp) begin miscompares++; $display("FAIL %s got %b want %b", e.name, m_i, e.exp); end
        e = sb.pop_front(); vectors++;
        if (irq_status !== e.exp) begin miscompares++; $display("FAIL %s got %b want %b", e.name, irq_status, e.exp); end
        s_i[3] = 1'b0;
        sb.push_back('{"en_m_i_low", 4'b0011});
        sb.push_back('{"en_fall_flag", 4'b1000});
        step(DC + 4);
        e = sb.pop_front(); vectors++;
        if (m_i !== e.exp) begin miscompares++; $display("FAIL %s got %b want %b", e.name, m_i, e.exp); end
        e = sb.pop_front(); vectors++;
        if (irq_status !== e.exp) begin miscompares++; $display("FAIL %s got %b want %b", e.name, irq_status, e.exp); end
        fall_en = 4'b0000;
        sb.push_back('{"en_flag_kept", 4'b1000});
        step(2);
        e = sb.pop_front(); vectors++;
        if (irq_status !== e.exp) begin miscompares++; $display("FAIL %s got %b want %b", e.name, irq_status, e.exp); end
        irq_clr = 4'b1111; step(1); irq_clr = 4'b0000;
        step(2);
        $display("enables irq_status=%b", irq_status);
    endtask

    task automatic test_async_reset();
        exp_t e;
        rise_en = 4'b1111; fall_en = 4'b0000;
        s_i = 4'hF;
        step(3);
        #2;
        rstn = 1'b0;
        sb.push_back('{"arst_m_i", 4'b0000});
        sb.push_back('{"arst_status", 4'b0000});
        sb.push_back('{"arst_irq", 4'b0000});
        #1;
        e = sb.pop_front(); vectors++;
        if (m_i !== e.exp) begin miscompares++; $display("FAIL %s got %b want %b", e.name, m_i, e.exp); end
        e = sb.pop_front(); vectors++;
        if (irq_status !== e.exp) begin miscompares++; $display("FAIL %s got %b want %b", e.name, irq_status, e.exp); end
        e = sb.pop_front(); vectors++;
        if ({3'b000, irq} !== e.exp) begin miscompares++; $display("FAIL %s got %b want %b", e.name, irq, e.exp[0]); end
        step(2);
        rstn = 1'b1;
        sb.push_back('{"arst_m_i_before", 4'b0000});
        step(DC + 1);
        e = sb.pop_front(); vectors++;
        if (m_i !== e.exp) begin miscompares++; $display("FAIL %s got %b want %b", e.name, m_i, e.exp); end
        sb.push_back('{"arst_m_i_after", 4'hF});
        sb.push_back('{"arst_rise_flags", 4'hF});
        step(1);
        e = sb.pop_front(); vectors++;
        if (m_i !== e.exp) begin miscompares++; $display("FAIL %s got %b want %b", e.name, m_i, e.exp); end
        e = sb.pop_front(); vectors++;
        if (irq_status !== e.exp) begin miscompares++; $display("FAIL %s got %b want %b", e.name, irq_status, e.exp); end
        sb.push_back('{"arst_irq_after", 4'b0001});
        step(1);
        e = sb.pop_front(); vectors++;
        if ({3'b000, irq} !== e.exp) begin miscompares++; $display("FAIL %s got %b want %b", e.name, irq, e.exp[0]); end
        $display("async_reset m_i=%b irq_status=%b", m_i, irq_status);
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_clean_edge();
        test_bounce();
        test_clear_race();
        test_enables();
        test_async_reset();
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain got %0d entries want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
